// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the divided-clock period meter: FSM encoding and counter width.
package clk_meter_pkg;

   localparam int CW = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

endpackage

// File: rtl/clk_period_meter_if.sv
// Slow-clock input and measurement/status outputs of one period meter.
interface clk_period_meter_if;
   import clk_meter_pkg::*;

   logic          sig_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          valid;
   logic          locked;
   logic          timeout;

   modport master (
      output sig_in,
      input  period, high_time, valid, locked, timeout
   );

   modport slave (
      input  sig_in,
      output period, high_time, valid, locked, timeout
   );

endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Two-flop synchronizer plus delay flop for an asynchronous level; flags rising and falling edges.
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic s1, s2, s3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow clock and tracks lock / loss of signal.
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int N        = 10000,
   parameter int TOL      = 4,
   parameter int LOCK_CNT = 3,
   parameter int TIMEOUT  = 20000
) (
   input  logic              clk,
   input  logic              rst,
   clk_period_meter_if.slave mif
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic signed [16:0] N_S   = 17'(N);
   localparam logic signed [16:0] TOL_S = 17'(TOL);
   localparam logic [CW-1:0]      TO_LAST = CW'(TIMEOUT - 1);

   function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
      return (v == '1) ? v : v + CW'(1);
   endfunction

   function automatic logic [GW-1:0] good_sat_inc(input logic [GW-1:0] g);
      return (g == GW'(LOCK_CNT)) ? g : g + GW'(1);
   endfunction

   function automatic logic signed [16:0] abs17(input logic signed [16:0] v);
      return (v < 0) ? -v : v;
   endfunction

   logic rise, fall;

   sync_edge_det u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (mif.sig_in),
      .rise (rise),
      .fall (fall)
   );

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [GW-1:0] good, good_nxt;
   logic [CW-1:0] period_r, period_nxt;
   logic [CW-1:0] high_r, high_nxt;
   logic          valid_r, valid_nxt;
   logic          timeout_r, timeout_nxt;

   logic [CW-1:0]      cnt_p1;
   logic               cnt_sat;
   logic signed [16:0] dev;
   logic               in_tol;

   // cnt holds (cycles since last rise - 1), so cnt+1 is the period closing on this rise
   assign cnt_p1  = cnt + CW'(1);
   assign cnt_sat = (cnt == '1);
   assign dev     = $signed({1'b0, cnt}) + 17'sd1 - N_S;
   assign in_tol  = (abs17(dev) <= TOL_S);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (rise) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_sat_inc(cnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         good      <= '0;
         period_r  <= '0;
         high_r    <= '0;
         valid_r   <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state     <= state_nxt;
         good      <= good_nxt;
         period_r  <= period_nxt;
         high_r    <= high_nxt;
         valid_r   <= valid_nxt;
         timeout_r <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      good_nxt    = good;
      period_nxt  = period_r;
      high_nxt    = high_r;
      valid_nxt   = 1'b0;
      timeout_nxt = timeout_r;
      case (state)
         IDLE: begin
            // First edge after idle only starts the count; there is no complete period yet
            if (rise) begin
               state_nxt   = MEASURE;
               timeout_nxt = 1'b0;
            end
         end
         MEASURE, LOCKED: begin
            if (rise && !cnt_sat) begin
               period_nxt = cnt_p1;
               valid_nxt  = 1'b1;
               if (in_tol) begin
                  good_nxt = good_sat_inc(good);
                  if (good_nxt == GW'(LOCK_CNT)) state_nxt = LOCKED;
               end else begin
                  good_nxt  = '0;
                  state_nxt = MEASURE;
               end
            end else if (!rise && cnt == TO_LAST) begin
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
               good_nxt    = '0;
            end
            if (fall) high_nxt = cnt_p1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mif.period    = period_r;
   assign mif.high_time = high_r;
   assign mif.valid     = valid_r;
   assign mif.locked    = (state == LOCKED);
   assign mif.timeout   = timeout_r;

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Receive-side checker for the divided clocks produced by the team's counter-based clock dividers. Samples an asynchronous slow clock input in the fast `clk` domain, measures its period and high time in `clk` cycles, and reports lock when consecutive periods match the expected value within a tolerance. Sits beside each divider output and feeds status and debug registers.

## Interface
- `N`, 10000: expected period of `sig_in` in `clk` cycles.
- `TOL`, 4: allowed absolute deviation of the measured period from `N`.
- `LOCK_CNT`, 3: number of consecutive in-tolerance periods required to assert `locked`.
- `TIMEOUT`, 20000: number of `clk` cycles without a rising edge that declares loss of signal. Must be at most 65535.

- `clk` in 1: system clock. Clock and reset are named as in the rest of the codebase.
- `rst` in 1: reset, asynchronous, active-low.
- `sig_in` in 1: slow clock under test, asynchronous to `clk`.
- `period` out 16: last measured period in `clk` cycles.
- `high_time` out 16: `clk` cycles from the last rising edge to the following falling edge.
- `valid` out 1: one-cycle pulse when `period` updates.
- `locked` out 1: level; high while `sig_in` is in lock.
- `timeout` out 1: level; high while `sig_in` is declared lost.

## Operation
- **Input sampling.**
  - `sig_in` passes through a 2-flop synchronizer (`s1`, `s2`) followed by a delay flop `s3`.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- **Counter `cnt`** (16 bit).
  - Cleared to 0 on `rise`.
  - Otherwise increments, saturating at 0xFFFF.
- **FSM states:** IDLE, MEASURE, LOCKED.
  - IDLE: on `rise`, go to MEASURE and clear `timeout`. No `valid` is produced, because the first edge gives no complete period.
  - MEASURE / LOCKED on `rise`:
    - `period <= cnt+1`; pulse `valid`.
    - In tolerance means `|cnt+1 − N| ≤ TOL`; compute with 17-bit signed arithmetic.
    - In tolerance: `good` increments, saturating at `LOCK_CNT`. When `good` reaches `LOCK_CNT`, go to LOCKED.
    - Out of tolerance: clear `good`, go to MEASURE, deassert `locked`.
  - On `fall` in MEASURE / LOCKED: `high_time <= cnt+1`.
  - Timeout in MEASURE / LOCKED: if `cnt == TIMEOUT-1` with no `rise`, go to IDLE, set `timeout`, clear `locked` and `good`. `period` and `high_time` hold their values.
- **Outputs.**
  - `locked` is 1 exactly when the state is LOCKED.
  - `timeout` stays set until the next `rise`.
- **Boundary cases.**
  - If `rise` and the timeout condition occur in the same cycle, the rise wins and is processed as a normal period.
  - When `cnt` is saturated, no measurement is taken. Unreachable while `TIMEOUT ≤ 65535`.
  - Asserting `rst` mid-measurement aborts immediately and restores all reset values.

## Timing
- **Reset values:**
  - `period`, `high_time` = 0.
  - `valid`, `locked`, `timeout` = 0.
  - State IDLE; `cnt`, `good` = 0; `s1`, `s2`, `s3` = 0.
- **Latency.** If clock edge k is the first to sample `sig_in` high, `rise` is true during cycle k+1→k+2. `valid`, `period` and `locked` update on edge k+2. Total latency is 2–3 `clk` cycles from the `sig_in` transition.
- **Measurement.** A `sig_in` with a period of exactly P `clk` cycles reports `period = P`. A divider toggling every N/2 cycles therefore reports N.
- **Input constraint.** `sig_in` high and low phases must each be at least 2 `clk` cycles. Shorter pulses may be missed and are not an error.
- `valid` is never high for two consecutive cycles.

## Structure
- **Shared package `clk_meter_pkg`:**
  - FSM state encoding (IDLE=0, MEASURE=1, LOCKED=2).
  - Counter width constant `CW=16`.
- **Sub-module `sync_edge_det`:**
  - Contains the 3-flop chain and the `rise`/`fall` outputs.
  - Reused by other clock-domain-crossing monitors.
- **Top level:** counter, FSM and tolerance compare.

## Test plan
Benches run with `N=10`, `TOL=1`, `LOCK_CNT=3`, `TIMEOUT=25`.

- **Clean lock.** Drive a period-10 square wave (5 high / 5 low).
  - The first `rise` produces no `valid`.
  - The next three periods each pulse `valid` with `period=10`, `high_time=5`.
  - `locked` rises with the third `valid`.
- **Tolerance edge.** Drive periods 11, 9, 11.
  - Result: lock.
  - A following period of 12 → `locked=0`, state MEASURE, `good=0`.
  - Three further periods of 10 → relock.
- **Loss of signal.** Lock, then hold `sig_in` low.
  - 25 cycles after the last `rise`: `timeout=1`, `locked=0`, `period` still 10.
  - Resuming the input clears `timeout` on its first `rise`, with no `valid` on that rise.
- **Simultaneous event.** Place a `rise` on exactly the cycle where `cnt=24`.
  - `valid=1`, `period=25`, `timeout=0`.
- **Reset mid-operation.** Assert `rst` low while locked and mid-period.
  - All outputs go to 0 asynchronously, before the next `clk` edge.
  - After release, the meter requires one unmeasured edge plus three good periods to relock.
- **Duty cycle.** Drive 3 high / 7 low.
  - `period=10`, `high_time=3`.
